ddrphy_gpll_dps_ctrl: RTL and testbench

//  Initiator-side sequencer for the DDR PHY GPLL reset, lock and dynamic-phase-shift (DPS) ports.

---
 rtl/ddrphy_gpll_dps_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ddrphy_gpll_dps_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ddrphy_gpll_dps_ctrl.sv
// GPLL reset/lock sequencer and dynamic-phase-shift stepper for the DDR PHY.
// Holds the PLL in reset, waits for a stable synchronised lock, ungates
// clkout0, then turns host shift requests into one dps_en strobe per step.
// Every output is registered from the next state so the PLL sees clean edges.
module ddrphy_gpll_dps_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int DONE_TIMEOUT = 255,
    parameter int STEP_W       = 8,
    parameter int STEP_GAP     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    output logic              pll_rst,
    output logic              clkout0_gate,
    output logic              dps_en,
    output logic              dps_dir,
    input  logic              dps_done,
    input  logic              relock_req,
    input  logic              shift_req,
    input  logic              shift_dir,
    input  logic [STEP_W-1:0] shift_steps,
    output logic              ready,
    output logic              busy,
    output logic              shift_done,
    output logic              shift_err
);

    localparam int RST_W  = $clog2(RST_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W  = $clog2(DONE_TIMEOUT + 1);
    localparam int GAP_W  = $clog2(STEP_GAP + 2);

    typedef enum logic [2:0] {
        S_RST, S_WAIT_LOCK, S_UNGATE, S_IDLE,
        S_SETUP, S_STROBE, S_WAIT_DONE, S_GAP
    } state_t;

    state_t              state, next;
    logic                lock_meta, lock_s;
    logic [RST_W-1:0]    rst_cnt, rst_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt, lock_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_d;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
    logic [STEP_W-1:0]   steps_left, steps_d;
    logic                dps_dir_d, shift_done_d, shift_err_d;
    logic                active, locked_phase;

    // A request is in flight in any of the stepping states.
    assign active       = state inside {S_SETUP, S_STROBE, S_WAIT_DONE, S_GAP};
    // From UNGATE onward a drop of lock_s aborts everything and relocks.
    assign locked_phase = active || state inside {S_UNGATE, S_IDLE};

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, counter and event logic; lock loss takes priority over all.
    always_comb begin
        next         = state;
        rst_cnt_d    = rst_cnt;
        lock_cnt_d   = lock_cnt;
        tmo_cnt_d    = tmo_cnt;
        gap_cnt_d    = gap_cnt;
        steps_d      = steps_left;
        dps_dir_d    = dps_dir;
        shift_done_d = 1'b0;
        shift_err_d  = shift_err;
        if (locked_phase && !lock_s) begin
            next      = S_RST;
            rst_cnt_d = '0;
            steps_d   = '0;
            if (active) begin
                shift_err_d  = 1'b1;
                shift_done_d = 1'b1;
            end
        end else begin
            case (state)
                S_RST: begin
                    if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                        next       = S_WAIT_LOCK;
                        rst_cnt_d  = '0;
                        lock_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt + RST_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (!lock_s)
                        lock_cnt_d = '0;
                    else if (lock_cnt == LOCK_W'(LOCK_STABLE - 1))
                        next = S_UNGATE;
                    else
                        lock_cnt_d = lock_cnt + LOCK_W'(1);
                end
                S_UNGATE: next = S_IDLE;
                S_IDLE: begin
                    if (relock_req) begin
                        next      = S_RST;
                        rst_cnt_d = '0;
                    end else if (shift_req) begin
                        shift_err_d = 1'b0;
                        if (shift_steps == '0) begin
                            shift_done_d = 1'b1;
                        end else begin
                            dps_dir_d = shift_dir;
                            steps_d   = shift_steps;
                            next      = S_SETUP;
                        end
                    end
                end
                S_SETUP: next = S_STROBE;
                S_STROBE: begin
                    tmo_cnt_d = '0;
                    next      = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (dps_done) begin
                        steps_d = steps_left - STEP_W'(1);
                        if (steps_left == STEP_W'(1)) begin
                            shift_done_d = 1'b1;
                            next         = S_IDLE;
                        end else begin
                            gap_cnt_d = '0;
                            next      = (STEP_GAP == 0) ? S_STROBE : S_GAP;
                        end
                    end else if (tmo_cnt == TMO_W'(DONE_TIMEOUT - 1)) begin
                        shift_err_d  = 1'b1;
                        shift_done_d = 1'b1;
                        steps_d      = '0;
                        next         = S_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_cnt + TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(STEP_GAP - 1))
                        next = S_STROBE;
                    else
                        gap_cnt_d = gap_cnt + GAP_W'(1);
                end
                default: next = S_RST;
            endcase
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RST;
            rst_cnt      <= '0;
            lock_cnt     <= '0;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            steps_left   <= '0;
            pll_rst      <= 1'b1;
            clkout0_gate <= 1'b1;
            dps_en       <= 1'b0;
            dps_dir      <= 1'b0;
            ready        <= 1'b0;
            busy         <= 1'b0;
            shift_done   <= 1'b0;
            shift_err    <= 1'b0;
        end else begin
            state        <= next;
            rst_cnt      <= rst_cnt_d;
            lock_cnt     <= lock_cnt_d;
            tmo_cnt      <= tmo_cnt_d;
            gap_cnt      <= gap_cnt_d;
            steps_left   <= steps_d;
            pll_rst      <= (next == S_RST);
            clkout0_gate <= next inside {S_RST, S_WAIT_LOCK, S_UNGATE};
            dps_en       <= (next == S_STROBE);
            dps_dir      <= dps_dir_d;
            ready        <= (next == S_IDLE);
            busy         <= next inside {S_SETUP, S_STROBE, S_WAIT_DONE, S_GAP};
            shift_done   <= shift_done_d;
            shift_err    <= shift_err_d;
        end
    end

endmodule

// File: tb/tb_ddrphy_gpll_dps_ctrl.sv
// Bench for the GPLL sequencer: PLL response model plus timing expectations
// derived from sync delay, reset length, lock window, step latency and gap.
module tb_ddrphy_gpll_dps_ctrl;

    localparam int RST_CYCLES   = 16;
    localparam int LOCK_STABLE  = 64;
    localparam int DONE_TIMEOUT = 255;
    localparam int STEP_W       = 8;
    localparam int STEP_GAP     = 2;

    logic              clk = 1'b0;
    logic              rst_n, pll_lock, relock_req, shift_req, shift_dir;
    logic              dps_done = 1'b0;
    logic [STEP_W-1:0] shift_steps;
    logic              pll_rst, clkout0_gate, dps_en, dps_dir, ready, busy, shift_done, shift_err;

    int checks = 0, failures = 0, cyc = 0;
    int lat = 5, pll_cnt = 0, en_dbl = 0, dir_bad = 0;
    bit mute = 1'b0, exp_dir = 1'b0, prev_en = 1'b0;
    int en_q[$];

    ddrphy_gpll_dps_ctrl #(
        .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE), .DONE_TIMEOUT(DONE_TIMEOUT),
        .STEP_W(STEP_W), .STEP_GAP(STEP_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_rst(pll_rst),
        .clkout0_gate(clkout0_gate), .dps_en(dps_en), .dps_dir(dps_dir), .dps_done(dps_done),
        .relock_req(relock_req), .shift_req(shift_req), .shift_dir(shift_dir),
        .shift_steps(shift_steps), .ready(ready), .busy(busy), .shift_done(shift_done),
        .shift_err(shift_err)
    );

    always #5 clk = ~clk;

    // Cycle label: value seen between posedge k and posedge k+1 is k.
    always @(posedge clk) cyc <= cyc + 1;

    // PLL model: dps_done for one cycle, lat cycles after each dps_en.
    always @(negedge clk) begin
        dps_done = 1'b0;
        if (rst_n !== 1'b1) pll_cnt = 0;
        else if (dps_en && !mute) pll_cnt = lat;
        else if (pll_cnt > 0) begin
            pll_cnt--;
            if (pll_cnt == 0) dps_done = 1'b1;
        end
    end

    // Record strobe times, back-to-back strobes and direction at each strobe.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dps_en) begin
                en_q.push_back(cyc);
                if (prev_en) en_dbl++;
                if (dps_dir !== exp_dir) dir_bad++;
            end
            prev_en = dps_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait (checking the current cycle first) for: 0 ready, 1 pll_rst low,
    // 2 shift_done, 3 dps_en. Returns -1 if the bound expires.
    task automatic wait_for(input int sel, input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            if ((sel == 0 && ready === 1'b1) || (sel == 1 && pll_rst === 1'b0) ||
                (sel == 2 && shift_done === 1'b1) || (sel == 3 && dps_en === 1'b1)) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    // ready appears once lock_s has been high LOCK_STABLE cycles inside the
    // lock window, plus one cycle spent ungating.
    function automatic int ready_model(input int lock_rise, input int wait_start);
        return ((lock_rise > wait_start) ? lock_rise : wait_start) + LOCK_STABLE + 1;
    endfunction

    task automatic run_shift(input int n, input bit d, input int l, input bit mt, input bit poke);
        int a, at, exp_at, exp_en, bad;
        bit to;
        en_q.delete();
        lat = l; mute = mt; exp_dir = d;
        to = (n != 0) && (mt || l > DONE_TIMEOUT);
        a = cyc;
        shift_req = 1'b1; shift_dir = d; shift_steps = STEP_W'(n);
        tick();
        shift_req = 1'b0; shift_dir = 1'($urandom_range(0, 1)); shift_steps = STEP_W'($urandom);
        if (n != 0) begin
            chk("busy_after_accept", busy, 1);
            if (poke) begin
                shift_req = 1'b1; relock_req = 1'b1; shift_dir = ~d; shift_steps = 7;
                tick();
                shift_req = 1'b0; relock_req = 1'b0;
            end
        end
        wait_for(2, 3000, at);
        if (n == 0)  exp_at = a + 1;
        else if (to) exp_at = a + 2 + DONE_TIMEOUT + 1;
        else         exp_at = a + 2 + (n - 1) * (l + 1 + STEP_GAP) + l + 1;
        chk("shift_done_cycle", at, exp_at);
        exp_en = (n == 0) ? 0 : (to ? 1 : n);
        chk("dps_en_count", en_q.size(), exp_en);
        bad = 0;
        for (int i = 1; i < en_q.size(); i++)
            if (en_q[i] - en_q[i-1] != l + 1 + STEP_GAP) bad++;
        if (en_q.size() > 0 && en_q[0] != a + 2) bad++;
        chk("dps_en_spacing", bad, 0);
        chk("end_ready_busy_err", {ready, busy, shift_err}, {1'b1, 1'b0, to});
        if (n != 0) chk("dps_dir_held", dps_dir, d);
        tick();
        chk("shift_done_one_cycle", shift_done, 0);
    endtask

    initial begin
        int k0, a, e, r, g, at;
        rst_n = 1'b0; pll_lock = 1'b1; relock_req = 1'b0; shift_req = 1'b0;
        shift_dir = 1'b0; shift_steps = '0;
        repeat (3) tick();
        chk("reset_outputs", {pll_rst, clkout0_gate, dps_en, dps_dir, ready, busy, shift_done, shift_err},
            8'b1100_0000);

        // Reset release with lock already high.
        k0 = cyc; rst_n = 1'b1;
        wait_for(1, 100, at);
        chk("pll_rst_hold", at, k0 + RST_CYCLES);
        wait_for(0, 300, at);
        chk("initial_ready", at, ready_model(k0 + 2, k0 + RST_CYCLES));
        chk("gate_open", clkout0_gate, 0);

        // Relock from IDLE, then a one-cycle lock glitch inside the lock window.
        a = cyc; relock_req = 1'b1; tick(); relock_req = 1'b0;
        chk("relock_flags", {ready, clkout0_gate, pll_rst}, 3'b011);
        wait_for(1, 100, at);
        chk("relock_rst_hold", at, a + 1 + RST_CYCLES);
        g = $urandom_range(5, 50);
        repeat (g) tick();
        e = cyc; pll_lock = 1'b0; tick(); pll_lock = 1'b1;
        wait_for(0, 300, at);
        chk("glitch_ready", at, ready_model(e + 1 + 2, a + 1 + RST_CYCLES));

        // Shifts: zero steps, directed, randomized, timeout, timeout boundaries.
        run_shift(0, 1'b1, 5, 1'b0, 1'b0);
        run_shift(3, 1'b1, 5, 1'b0, 1'b0);
        for (int it = 0; it < 5; it++)
            run_shift($urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(1, 8), 1'b0, 1'(it % 2));
        run_shift(2, 1'b1, 5, 1'b1, 1'b0);
        run_shift(1, 1'b0, DONE_TIMEOUT, 1'b0, 1'b0);
        run_shift(1, 1'b1, DONE_TIMEOUT + 1, 1'b0, 1'b0);

        // relock_req wins over a simultaneous shift_req.
        en_q.delete(); mute = 1'b0;
        a = cyc; relock_req = 1'b1; shift_req = 1'b1; shift_steps = 3; tick();
        relock_req = 1'b0; shift_req = 1'b0;
        chk("prio_flags", {ready, busy, clkout0_gate, pll_rst}, 4'b0011);
        wait_for(0, 300, at);
        chk("prio_ready", at, ready_model(a + 3, a + 1 + RST_CYCLES));
        chk("prio_no_strobe", en_q.size(), 0);

        // Lock loss after the second of four steps.
        en_q.delete(); lat = 4; mute = 1'b0; exp_dir = 1'b0;
        shift_req = 1'b1; shift_dir = 1'b0; shift_steps = 4; tick(); shift_req = 1'b0;
        wait_for(3, 100, at); tick();
        wait_for(3, 100, at);
        e = cyc; pll_lock = 1'b0;
        wait_for(2, 50, at);
        chk("lockloss_done_cycle", at, e + 3);
        chk("lockloss_flags", {shift_err, clkout0_gate, pll_rst, ready, busy}, 5'b11100);
        wait_for(1, 100, at);
        chk("lockloss_rst_hold", at, e + 3 + RST_CYCLES);
        repeat (10) tick();
        chk("no_ready_while_unlocked", ready, 0);
        r = cyc; pll_lock = 1'b1;
        wait_for(0, 300, at);
        chk("lockloss_relock_ready", at, ready_model(r + 2, e + 3 + RST_CYCLES));
        chk("lockloss_strobes", en_q.size(), 2);

        // Asynchronous reset in the middle of a shift.
        en_q.delete(); lat = 6; exp_dir = 1'b1;
        shift_req = 1'b1; shift_dir = 1'b1; shift_steps = 4; tick(); shift_req = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {pll_rst, clkout0_gate, dps_en, dps_dir, ready, busy, shift_done, shift_err},
            8'b1100_0000);
        tick(); tick();
        k0 = cyc; rst_n = 1'b1;
        wait_for(0, 300, at);
        chk("post_reset_ready", at, ready_model(k0 + 2, k0 + RST_CYCLES));
        run_shift(2, 1'b0, 3, 1'b0, 1'b0);

        chk("no_back_to_back_strobe", en_dbl, 0);
        chk("dir_stable_at_strobe", dir_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
